// File: rtl/rnd_dispatch.sv
// rtl/rnd_dispatch.sv - warmup filter, word FIFO and round-robin dispatcher for the LFSR random source
module rnd_dispatch #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int WARMUP = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         rnd_in,
    input  logic                     rnd_valid_in,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    output logic [WIDTH-1:0]         rnd_out,
    output logic                     rnd_out_valid,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int RW  = $clog2(NREQ);
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // With no warmup the dispatcher comes out of reset already running.
    localparam state_t ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    state_t             state_q, state_d;
    logic [WCW-1:0]     wcnt_q, wcnt_d;
    logic               ready_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic [7:0]         drop_q;
    logic [RW-1:0]      rr_q;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0]   rnd_out_q;

    logic               run;
    logic [NREQ-1:0]    eligible;
    logic               found;
    logic [RW-1:0]      pick;
    logic [RW-1:0]      rr_next;
    int                 idx;
    logic               pop, push, drop, full;

    // Warmup counting: discarded strobes advance the counter until the last one moves us to RUN.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (state_q == ST_WARMUP && rnd_valid_in) begin
            wcnt_d = wcnt_q + WCW'(1);
            if (wcnt_q == WCW'(WARMUP - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Round-robin pick: first requester at or after rr, skipping whoever was granted last cycle.
    always_comb begin
        eligible = req & ~gnt_q;
        found    = 1'b0;
        pick     = '0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = RW'(idx);
            end
        end
    end

    // FIFO control: pop only from words already stored, push on free slot or simultaneous pop.
    always_comb begin
        run     = (state_q == ST_RUN);
        full    = (level_q == LW'(DEPTH));
        pop     = run && (level_q != '0) && found;
        push    = run && rnd_valid_in && (!full || pop);
        drop    = run && rnd_valid_in && !push;
        gnt_d   = pop ? (NREQ'(1) << pick) : '0;
        rr_next = (pick == RW'(NREQ - 1)) ? '0 : pick + RW'(1);
    end

    // Word storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rnd_in;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            wcnt_q    <= '0;
            ready_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            drop_q    <= '0;
            rr_q      <= '0;
            gnt_q     <= '0;
            rnd_out_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ready_q <= (state_d == ST_RUN);
            gnt_q   <= gnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rnd_out_q <= mem_q[rd_ptr_q];
                rr_q      <= rr_next;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (drop && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign gnt           = gnt_q;
    assign rnd_out       = rnd_out_q;
    assign rnd_out_valid = |gnt_q;
    assign ready         = ready_q;
    assign fifo_level    = level_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_rnd_dispatch.sv
// tb/tb_rnd_dispatch.sv - scoreboard bench for rnd_dispatch against a queue-based reference model
module tb_rnd_dispatch;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int WARMUP = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [WIDTH-1:0]       rnd_in = '0;
    logic                   rnd_valid_in = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ-1:0]        gnt;
    logic [WIDTH-1:0]       rnd_out;
    logic                   rnd_out_valid;
    logic                   ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [7:0]             drop_cnt;

    rnd_dispatch #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
        .clk           (clk),
        .rst           (rst),
        .rnd_in        (rnd_in),
        .rnd_valid_in  (rnd_valid_in),
        .req           (req),
        .gnt           (gnt),
        .rnd_out       (rnd_out),
        .rnd_out_valid (rnd_out_valid),
        .ready         (ready),
        .fifo_level    (fifo_level),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [WIDTH-1:0] word;
    } exp_t;

    exp_t             exp_q[$];

    // Reference model state: what the dispatcher should look like after the next edge.
    bit               m_run;
    int               m_wcnt;
    logic [WIDTH-1:0] m_fifo[$];
    int               m_drop;
    int               m_rr;
    int               m_last;
    bit               m_ready;
    bit               m_gnt_now;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        m_run     = (WARMUP == 0);
        m_wcnt    = 0;
        m_fifo.delete();
        m_drop    = 0;
        m_rr      = 0;
        m_last    = -1;
        m_ready   = 0;
        m_gnt_now = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(logic [NREQ-1:0] r, logic v, logic [WIDTH-1:0] w);
        int   pick;
        int   id;
        exp_t e;
        pick = -1;
        if (!m_run) begin
            if (v) begin
                m_wcnt++;
                if (m_wcnt == WARMUP) m_run = 1;
            end
            m_last    = -1;
            m_gnt_now = 0;
            m_ready   = m_run;
            return;
        end
        if (m_fifo.size() > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                id = (m_rr + k) % NREQ;
                if (pick < 0 && r[id] && id != m_last) pick = id;
            end
        end
        if (pick >= 0) begin
            e.gnt  = NREQ'(1) << pick;
            e.word = m_fifo.pop_front();
            exp_q.push_back(e);
            m_rr = (pick + 1) % NREQ;
        end
        m_last    = pick;
        m_gnt_now = (pick >= 0);
        if (v) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else if (m_drop < 255) m_drop++;
        end
        m_ready = 1;
    endfunction

    task automatic apply(logic [NREQ-1:0] r, logic v, logic [WIDTH-1:0] w);
        req          = r;
        rnd_valid_in = v;
        rnd_in       = w;
        model_step(r, v, w);
    endtask

    task automatic cyc(logic [NREQ-1:0] r, logic v, logic [WIDTH-1:0] w);
        @(negedge clk);
        apply(r, v, w);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apply('0, 1'b0, '0);
    endtask

    // Monitor: status every cycle, and one scoreboard entry per grant the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("valid_timing", rnd_out_valid, m_gnt_now);
                chk("fifo_level", fifo_level, m_fifo.size());
                chk("drop_cnt", drop_cnt, m_drop);
                chk("ready", ready, m_ready);
                if (rnd_out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", gnt, '0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("gnt", gnt, e.gnt);
                        chk("rnd_out", rnd_out, e.word);
                    end
                end else begin
                    chk("gnt_idle", gnt, '0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        chk("rst_gnt", gnt, '0);
        chk("rst_valid", rnd_out_valid, 0);
        chk("rst_rnd_out", rnd_out, '0);
        chk("rst_ready", ready, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);
        release_reset();

        // Warmup discards 0xA and 0xB; 0xC is granted two cycles after its strobe.
        cyc(4'b0001, 1'b1, 32'hA);
        @(negedge clk); chk("t1_ready_early", ready, 0);  apply(4'b0001, 1'b1, 32'hB);
        @(negedge clk); chk("t1_ready_up", ready, 1);     apply(4'b0001, 1'b1, 32'hC);
        @(negedge clk); chk("t1_no_bypass", gnt, '0);     apply(4'b0001, 1'b0, '0);
        @(negedge clk); chk("t1_gnt", gnt, 4'b0001); chk("t1_word", rnd_out, 32'hC);
        apply(4'b0001, 1'b0, '0);
        cyc('0, 1'b0, '0);

        // Four buffered words drained back-to-back with all requesters held.
        for (int i = 0; i < 4; i++) cyc('0, 1'b1, 32'h100 + i);
        @(negedge clk); chk("t2_level_full", fifo_level, 4); apply(4'b1111, 1'b0, '0);
        for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b0, '0);
        @(negedge clk); chk("t2_level_empty", fifo_level, 0); apply('0, 1'b0, '0);

        // Full FIFO drops then saturates the drop counter.
        for (int i = 0; i < 4; i++) cyc('0, 1'b1, 32'h200 + i);
        for (int i = 0; i < 3; i++) cyc('0, 1'b1, 32'hDEAD0 + i);
        @(negedge clk); chk("t3_level", fifo_level, 4); chk("t3_drop3", drop_cnt, 3);
        apply('0, 1'b1, 32'hDEAD9);
        for (int i = 0; i < 300; i++) cyc('0, 1'b1, $urandom);
        @(negedge clk); chk("t3_drop_sat", drop_cnt, 255); apply('0, 1'b0, '0);

        // Push and pop together at full.
        cyc(4'b0001, 1'b1, 32'h7A11);
        @(negedge clk); chk("t4_level", fifo_level, 4); apply('0, 1'b0, '0);
        for (int i = 0; i < 6; i++) cyc(4'b1111, 1'b0, '0);

        // Held requests with a sparse mask; refilled FIFO.
        for (int i = 0; i < 4; i++) cyc('0, 1'b1, 32'h300 + i);
        for (int i = 0; i < 8; i++) cyc(4'b1011, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b1, 32'h400 + i);
        for (int i = 0; i < 6; i++) cyc(4'b0001, 1'b0, '0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(NREQ'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
        end

        // Mid-transfer asynchronous reset with three words buffered and a grant showing.
        for (int i = 0; i < 8; i++) cyc(4'b1111, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc('0, 1'b1, 32'h500 + i);
        cyc(4'b0001, 1'b0, '0);
        @(negedge clk);
        chk("t6_pre_level", fifo_level, 3);
        chk("t6_pre_gnt", gnt, 4'b0001);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("t6_gnt", gnt, '0);
        chk("t6_valid", rnd_out_valid, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_ready", ready, 0);
        chk("t6_drop", drop_cnt, 0);
        release_reset();
        cyc(4'b1111, 1'b1, 32'h600);
        cyc(4'b1111, 1'b1, 32'h601);
        @(negedge clk); chk("t6_warm_gnt", gnt, '0); apply(4'b1111, 1'b1, 32'h602);
        for (int i = 0; i < 6; i++) cyc(4'b1111, 1'b0, '0);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
